// File: rtl/number_game_sequencer.sv
// Round controller for the number game.
// It runs the game phases, the game-second tick, the countdowns and the score.
module number_game_sequencer #(
   parameter int TICK_N    = 50000000,
   parameter int PREP_SECS = 5
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic       abort,
   input  logic       hit,
   input  logic [6:0] goal_in,
   input  logic [3:0] diff_in,
   output logic [2:0] phase,
   output logic [2:0] prep_count,
   output logic [4:0] progress,
   output logic [6:0] score,
   output logic [6:0] goal,
   output logic       load_number
);

   localparam int CW = (TICK_N > 1) ? $clog2(TICK_N) : 1;
   localparam logic [CW-1:0] TICK_MAX = CW'(TICK_N - 1);
   localparam logic [2:0] PREP_V = 3'(PREP_SECS);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PREP = 3'd1,
      S_PLAY = 3'd2,
      S_WIN  = 3'd3,
      S_LOSE = 3'd4
   } phase_e;

   phase_e        phase_q, phase_d;
   logic [2:0]    prep_q, prep_d;
   logic [4:0]    prog_q, prog_d;
   logic [6:0]    score_q, score_d;
   logic [6:0]    goal_q, goal_d;
   logic [3:0]    diff_q, diff_d;
   logic          load_q, load_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          tick;
   logic [4:0]    limit;
   logic [6:0]    score_inc;
   logic [6:0]    goal_c;
   logic [3:0]    diff_c;

   assign tick      = (cnt_q == TICK_MAX);
   assign limit     = 5'd21 - {diff_q, 1'b0};
   assign score_inc = score_q + 7'd1;

   always_comb begin
      goal_c = goal_in;
      if (goal_in == 7'd0) begin
         goal_c = 7'd1;
      end else if (goal_in > 7'd99) begin
         goal_c = 7'd99;
      end
   end

   always_comb begin
      diff_c = diff_in;
      if (diff_in == 4'd0) begin
         diff_c = 4'd1;
      end else if (diff_in > 4'd10) begin
         diff_c = 4'd10;
      end
   end

   always_comb begin
      phase_d = phase_q;
      prep_d  = prep_q;
      prog_d  = prog_q;
      score_d = score_q;
      goal_d  = goal_q;
      diff_d  = diff_q;
      load_d  = 1'b0;
      cnt_d   = tick ? '0 : cnt_q + CW'(1);

      if (abort) begin
         phase_d = S_IDLE;
         prep_d  = 3'd0;
         prog_d  = 5'd0;
         score_d = 7'd0;
         cnt_d   = '0;
      end else begin
         unique case (phase_q)
            S_IDLE, S_WIN, S_LOSE: begin
               if (start) begin
                  goal_d  = goal_c;
                  diff_d  = diff_c;
                  score_d = 7'd0;
                  prep_d  = PREP_V;
                  cnt_d   = '0;
                  phase_d = S_PREP;
               end
            end
            S_PREP: begin
               if (tick) begin
                  if (prep_q > 3'd1) begin
                     prep_d = prep_q - 3'd1;
                  end else begin
                     prep_d  = 3'd0;
                     phase_d = S_PLAY;
                     prog_d  = limit;
                     cnt_d   = '0;
                     load_d  = 1'b1;
                  end
               end
            end
            S_PLAY: begin
               // a hit beats a timeout landing on the same edge
               if (hit) begin
                  score_d = score_inc;
                  if (score_inc >= goal_q) begin
                     phase_d = S_WIN;
                  end else begin
                     prog_d = limit;
                     cnt_d  = '0;
                     load_d = 1'b1;
                  end
               end else if (tick) begin
                  if (prog_q > 5'd1) begin
                     prog_d = prog_q - 5'd1;
                  end else begin
                     prog_d  = 5'd0;
                     phase_d = S_LOSE;
                  end
               end
            end
            default: begin
               phase_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         phase_q <= S_IDLE;
         prep_q  <= 3'd0;
         prog_q  <= 5'd0;
         score_q <= 7'd0;
         goal_q  <= 7'd0;
         diff_q  <= 4'd1;
         load_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         phase_q <= phase_d;
         prep_q  <= prep_d;
         prog_q  <= prog_d;
         score_q <= score_d;
         goal_q  <= goal_d;
         diff_q  <= diff_d;
         load_q  <= load_d;
         cnt_q   <= cnt_d;
      end
   end

   assign phase       = phase_q;
   assign prep_count  = prep_q;
   assign progress    = prog_q;
   assign score       = score_q;
   assign goal        = goal_q;
   assign load_number = load_q;

endmodule

// File: tb/tb_number_game_sequencer.sv
// Bench for number_game_sequencer with a 4-cycle game second.
// load_number pulses are matched against a queue of expected snapshots.
module tb_number_game_sequencer;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       hit = 1'b0;
   logic [6:0] goal_in = 7'd0;
   logic [3:0] diff_in = 4'd0;
   logic [2:0] phase;
   logic [2:0] prep_count;
   logic [4:0] progress;
   logic [6:0] score;
   logic [6:0] goal;
   logic       load_number;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] ph;
      logic [6:0] sc;
      logic [4:0] pr;
   } exp_t;

   exp_t lq[$];

   number_game_sequencer #(.TICK_N(4), .PREP_SECS(5)) dut (
      .clock(clock),
      .resetn(resetn),
      .start(start),
      .abort(abort),
      .hit(hit),
      .goal_in(goal_in),
      .diff_in(diff_in),
      .phase(phase),
      .prep_count(prep_count),
      .progress(progress),
      .score(score),
      .goal(goal),
      .load_number(load_number)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (resetn && load_number) begin
         exp_t e;
         checks++;
         if (lq.size() == 0) begin
            errors++;
            $display("FAIL load_unexpected: got 1 want 0 at %0t", $time);
         end else begin
            e = lq.pop_front();
            if (phase !== e.ph || score !== e.sc || progress !== e.pr) begin
               errors++;
               $display("FAIL load_snapshot: got ph=%0d sc=%0d pr=%0d want ph=%0d sc=%0d pr=%0d",
                        phase, score, progress, e.ph, e.sc, e.pr);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic start_game(input logic [6:0] g, input logic [3:0] d, input logic [4:0] lim);
      goal_in = g;
      diff_in = d;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      lq.push_back(exp_t'{3'd2, 7'd0, lim});
      cyc(20);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({phase, prep_count, progress, score, goal, load_number} !== 25'd0) begin
         errors++;
         $display("FAIL reset_state: got ph=%0d pc=%0d pr=%0d sc=%0d g=%0d ld=%0d want all 0",
                  phase, prep_count, progress, score, goal, load_number);
      end
      #22;
      resetn = 1'b1;
      cyc(1);
   endtask

   task automatic test_prep();
      int ep, eph;
      goal_in = 7'd3;
      diff_in = 4'd5;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      checks++;
      if (phase !== 3'd1 || prep_count !== 3'd5 || goal !== 7'd3) begin
         errors++;
         $display("FAIL prep_entry: got ph=%0d pc=%0d g=%0d want 1 5 3", phase, prep_count, goal);
      end
      for (int i = 1; i <= 20; i++) begin
         if (i == 20) lq.push_back(exp_t'{3'd2, 7'd0, 5'd11});
         cyc(1);
         ep  = (i < 20) ? 5 - i / 4 : 0;
         eph = (i < 20) ? 1 : 2;
         checks++;
         if (prep_count !== 3'(ep) || phase !== 3'(eph) || load_number !== (i == 20)) begin
            errors++;
            $display("FAIL prep_step%0d: got pc=%0d ph=%0d ld=%0d want %0d %0d %0d",
                     i, prep_count, phase, load_number, ep, eph, i == 20);
         end
      end
      checks++;
      if (progress !== 5'd11) begin
         errors++;
         $display("FAIL play_limit: got %0d want 11", progress);
      end
   endtask

   task automatic test_hits();
      for (int n = 1; n <= 3; n++) begin
         hit = 1'b1;
         if (n < 3) lq.push_back(exp_t'{3'd2, 7'(n), 5'd11});
         cyc(1);
         hit = 1'b0;
         checks++;
         if (score !== 7'(n) || progress !== 5'd11 || load_number !== (n < 3) ||
             phase !== ((n < 3) ? 3'd2 : 3'd3)) begin
            errors++;
            $display("FAIL hit%0d: got sc=%0d pr=%0d ld=%0d ph=%0d", n, score, progress,
                     load_number, phase);
         end
         cyc(2);
      end
      hit = 1'b1;
      cyc(3);
      hit = 1'b0;
      cyc(6);
      checks++;
      if (phase !== 3'd3 || score !== 7'd3 || progress !== 5'd11) begin
         errors++;
         $display("FAIL win_hold: got ph=%0d sc=%0d pr=%0d want 3 3 11", phase, score, progress);
      end
   endtask

   task automatic test_lose();
      start_game(7'd5, 4'd10, 5'd1);
      checks++;
      if (phase !== 3'd2 || progress !== 5'd1 || score !== 7'd0) begin
         errors++;
         $display("FAIL lose_entry: got ph=%0d pr=%0d sc=%0d want 2 1 0", phase, progress, score);
      end
      cyc(3);
      checks++;
      if (phase !== 3'd2) begin
         errors++;
         $display("FAIL lose_early: got ph=%0d want 2", phase);
      end
      cyc(1);
      checks++;
      if (phase !== 3'd4 || progress !== 5'd0 || score !== 7'd0) begin
         errors++;
         $display("FAIL lose_at4: got ph=%0d pr=%0d sc=%0d want 4 0 0", phase, progress, score);
      end
   endtask

   task automatic test_hit_vs_tick();
      start_game(7'd5, 4'd10, 5'd1);
      cyc(3);
      hit = 1'b1;
      lq.push_back(exp_t'{3'd2, 7'd1, 5'd1});
      cyc(1);
      hit = 1'b0;
      checks++;
      if (phase !== 3'd2 || score !== 7'd1 || progress !== 5'd1 || load_number !== 1'b1) begin
         errors++;
         $display("FAIL hit_vs_tick: got ph=%0d sc=%0d pr=%0d ld=%0d want 2 1 1 1",
                  phase, score, progress, load_number);
      end
      cyc(4);
      checks++;
      if (phase !== 3'd4 || score !== 7'd1) begin
         errors++;
         $display("FAIL hit_vs_tick_lose: got ph=%0d sc=%0d want 4 1", phase, score);
      end
   endtask

   task automatic test_clamp();
      start_game(7'd0, 4'd15, 5'd1);
      checks++;
      if (goal !== 7'd1 || progress !== 5'd1) begin
         errors++;
         $display("FAIL clamp_low: got g=%0d pr=%0d want 1 1", goal, progress);
      end
      cyc(4);
      start_game(7'd120, 4'd0, 5'd19);
      checks++;
      if (goal !== 7'd99 || progress !== 5'd19) begin
         errors++;
         $display("FAIL clamp_high: got g=%0d pr=%0d want 99 19", goal, progress);
      end
      cyc(4);
      checks++;
      if (progress !== 5'd18) begin
         errors++;
         $display("FAIL play_dec: got %0d want 18", progress);
      end
   endtask

   task automatic test_abort_reset();
      hit = 1'b1;
      lq.push_back(exp_t'{3'd2, 7'd1, 5'd19});
      cyc(1);
      hit = 1'b0;
      cyc(1);
      abort = 1'b1;
      start = 1'b1;
      goal_in = 7'd7;
      diff_in = 4'd3;
      cyc(1);
      abort = 1'b0;
      start = 1'b0;
      checks++;
      if (phase !== 3'd0 || score !== 7'd0 || progress !== 5'd0 || prep_count !== 3'd0 ||
          load_number !== 1'b0 || goal !== 7'd99) begin
         errors++;
         $display("FAIL abort: got ph=%0d sc=%0d pr=%0d pc=%0d ld=%0d g=%0d want 0 0 0 0 0 99",
                  phase, score, progress, prep_count, load_number, goal);
      end
      goal_in = 7'd50;
      diff_in = 4'd1;
      start = 1'b1;
      cyc(1);
      goal_in = 7'd9;
      hit = 1'b1;
      cyc(5);
      start = 1'b0;
      hit = 1'b0;
      checks++;
      if (phase !== 3'd1 || prep_count !== 3'd4 || goal !== 7'd50 || score !== 7'd0) begin
         errors++;
         $display("FAIL prep_ignore: got ph=%0d pc=%0d g=%0d sc=%0d want 1 4 50 0",
                  phase, prep_count, goal, score);
      end
      #3;
      resetn = 1'b0;
      #1;
      checks++;
      if ({phase, prep_count, progress, score, goal, load_number} !== 25'd0) begin
         errors++;
         $display("FAIL async_reset: got ph=%0d pc=%0d pr=%0d sc=%0d g=%0d ld=%0d want all 0",
                  phase, prep_count, progress, score, goal, load_number);
      end
      #2;
      resetn = 1'b1;
      cyc(2);
   endtask

   initial begin
      test_reset();
      test_prep();
      test_hits();
      test_lose();
      test_hit_vs_tick();
      test_clamp();
      test_abort_reset();
      checks++;
      if (lq.size() != 0) begin
         errors++;
         $display("FAIL load_missing: got %0d pending want 0", lq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
